// File: rtl/mac_tx_mii.sv
// MII transmit framer: preamble/SFD, byte-to-nibble serialisation, zero padding,
// CRC-32 FCS and inter-frame gap. All outputs are registered.
module mac_tx_mii #(
  parameter int PREAMBLE_NIBBLES = 15,
  parameter int MIN_FRAME        = 60,
  parameter int MAX_FRAME        = 1514,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic       tx_clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       tx_dv,
  output logic [3:0] tx_d,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam int CMAX = (IFG_NIBBLES > PREAMBLE_NIBBLES) ? IFG_NIBBLES : PREAMBLE_NIBBLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

  state_t      state, state_n;
  logic        hi, hi_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]  byte_q, byte_n;
  logic [10:0] bcnt, bcnt_n;
  logic [31:0] crc, crc_n;
  logic [31:0] sr, sr_n;
  logic        last_seen, last_n;
  logic        ready_n, dv_n, busy_n, done_n, under_n;
  logic [3:0]  d_n;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hi          <= 1'b0;
      cnt         <= '0;
      byte_q      <= 8'h00;
      bcnt        <= 11'd0;
      crc         <= 32'hFFFFFFFF;
      sr          <= 32'h0;
      last_seen   <= 1'b0;
      data_ready  <= 1'b0;
      tx_dv       <= 1'b0;
      tx_d        <= 4'h0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_n;
      hi          <= hi_n;
      cnt         <= cnt_n;
      byte_q      <= byte_n;
      bcnt        <= bcnt_n;
      crc         <= crc_n;
      sr          <= sr_n;
      last_seen   <= last_n;
      data_ready  <= ready_n;
      tx_dv       <= dv_n;
      tx_d        <= d_n;
      tx_busy     <= busy_n;
      tx_done     <= done_n;
      tx_underrun <= under_n;
    end
  end

  always_comb begin
    state_n = state;
    hi_n    = hi;
    cnt_n   = cnt;
    byte_n  = byte_q;
    bcnt_n  = bcnt;
    crc_n   = crc;
    sr_n    = sr;
    last_n  = last_seen;
    ready_n = 1'b0;
    dv_n    = tx_dv;
    d_n     = tx_d;
    busy_n  = tx_busy;
    done_n  = 1'b0;
    under_n = 1'b0;
    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        dv_n    = 1'b0;
        d_n     = 4'h0;
        busy_n  = 1'b0;
        crc_n   = 32'hFFFFFFFF;
        bcnt_n  = 11'd0;
        if (data_valid && data_ready) begin
          byte_n  = data_in;
          last_n  = data_last;
          state_n = S_PRE;
          cnt_n   = CW'(PREAMBLE_NIBBLES - 1);
          ready_n = 1'b0;
          dv_n    = 1'b1;
          d_n     = 4'h5;
          busy_n  = 1'b1;
        end
      end
      S_PRE: begin
        if (cnt == '0) begin
          state_n = S_SFD;
          d_n     = 4'hD;
        end else begin
          cnt_n = cnt - 1'b1;
          d_n   = 4'h5;
        end
      end
      S_SFD: begin
        state_n = S_DATA;
        hi_n    = 1'b0;
        d_n     = byte_q[3:0];
        crc_n   = crc_byte(crc, byte_q);
        bcnt_n  = bcnt + 11'd1;
      end
      S_DATA: begin
        if (!hi) begin
          hi_n    = 1'b1;
          d_n     = byte_q[7:4];
          ready_n = !last_seen && (bcnt != 11'(MAX_FRAME));
        end else if (last_seen) begin
          if (bcnt < 11'(MIN_FRAME)) begin
            state_n = S_PAD;
            hi_n    = 1'b0;
            d_n     = 4'h0;
            crc_n   = crc_byte(crc, 8'h00);
            bcnt_n  = bcnt + 11'd1;
          end else begin
            state_n = S_FCS;
            d_n     = ~crc[3:0];
            sr_n    = (~crc) >> 4;
            cnt_n   = CW'(7);
          end
        end else if (data_valid && data_ready) begin
          byte_n = data_in;
          last_n = data_last;
          hi_n   = 1'b0;
          d_n    = data_in[3:0];
          crc_n  = crc_byte(crc, data_in);
          bcnt_n = bcnt + 11'd1;
        end else begin
          // Underrun or oversize: send the uninverted CRC so the receiver sees a bad FCS.
          under_n = 1'b1;
          state_n = S_FCS;
          d_n     = crc[3:0];
          sr_n    = crc >> 4;
          cnt_n   = CW'(7);
        end
      end
      S_PAD: begin
        if (!hi) begin
          hi_n = 1'b1;
          d_n  = 4'h0;
        end else if (bcnt == 11'(MIN_FRAME)) begin
          state_n = S_FCS;
          d_n     = ~crc[3:0];
          sr_n    = (~crc) >> 4;
          cnt_n   = CW'(7);
        end else begin
          hi_n   = 1'b0;
          d_n    = 4'h0;
          crc_n  = crc_byte(crc, 8'h00);
          bcnt_n = bcnt + 11'd1;
        end
      end
      S_FCS: begin
        if (cnt == '0) begin
          state_n = S_IFG;
          dv_n    = 1'b0;
          d_n     = 4'h0;
          // The IDLE accept cycle is the last low cycle of the gap.
          cnt_n   = CW'(IFG_NIBBLES - 2);
        end else begin
          d_n    = sr[3:0];
          sr_n   = sr >> 4;
          cnt_n  = cnt - 1'b1;
          done_n = (cnt == CW'(1));
        end
      end
      S_IFG: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_tx_mii.sv
// Self-checking bench for mac_tx_mii: drives frames, captures the MII nibble stream
// and checks framing, padding, FCS, residue, gap and abort behaviour against a model.
module tb_mac_tx_mii;

  logic       tx_clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       tx_dv;
  logic [3:0] tx_d;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  mac_tx_mii dut (
    .tx_clk(tx_clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_last(data_last), .data_ready(data_ready), .tx_dv(tx_dv), .tx_d(tx_d),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun)
  );

  always #5 tx_clk = ~tx_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Monitor state
  logic [3:0] nibs[$];
  logic [3:0] frame_nibs[$];
  bit  in_frame = 0;
  bit  frame_ready = 0;
  int  cyc = 0;
  int  low_run = 0;
  int  gap_last = 0;
  int  done_cyc = 0;
  int  since_done = 0;
  int  done_pos = -1;
  int  frame_done_pos = -1;
  int  underrun_cnt = 0;
  int  dzero_viol = 0;

  always @(negedge tx_clk) begin
    cyc++;
    if (tx_underrun) underrun_cnt++;
    if (tx_dv) begin
      if (!in_frame) begin
        in_frame = 1;
        nibs.delete();
        gap_last = low_run;
        since_done = cyc - done_cyc;
        done_pos = -1;
      end
      low_run = 0;
      nibs.push_back(tx_d);
      if (tx_done) begin
        done_pos = nibs.size() - 1;
        done_cyc = cyc;
      end
    end else begin
      low_run++;
      if (tx_d != 4'h0) dzero_viol++;
      if (in_frame) begin
        in_frame = 0;
        frame_nibs = nibs;
        frame_done_pos = done_pos;
        frame_ready = 1;
      end
    end
  end

  logic [7:0] tx_bytes[0:2047];

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) tx_bytes[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_frame(input string tag, input int n, input bit ab);
    int plen, total;
    logic [31:0] crc, rcrc, fcs, res;
    logic [7:0] b, e;
    int errs;
    bit pre_ok;
    plen  = ab ? n : (n < 60 ? 60 : n);
    total = 16 + 2 * plen + 8;
    check({tag, "_nibbles"}, frame_nibs.size(), total);
    check({tag, "_underrun"}, underrun_cnt, ab ? 1 : 0);
    if (frame_nibs.size() != total) return;
    pre_ok = 1;
    for (int i = 0; i < 15; i++) if (frame_nibs[i] != 4'h5) pre_ok = 0;
    if (frame_nibs[15] != 4'hD) pre_ok = 0;
    check({tag, "_preamble"}, pre_ok, 1);
    crc = 32'hFFFFFFFF;
    rcrc = 32'hFFFFFFFF;
    errs = 0;
    for (int i = 0; i < plen; i++) begin
      b = {frame_nibs[17 + 2 * i], frame_nibs[16 + 2 * i]};
      e = (i < n) ? tx_bytes[i] : 8'h00;
      if (b != e) errs++;
      crc = crc_upd(crc, e);
      rcrc = crc_upd(rcrc, b);
    end
    check({tag, "_data"}, errs, 0);
    fcs = 32'h0;
    for (int k = 0; k < 8; k++) fcs[4*k +: 4] = frame_nibs[16 + 2 * plen + k];
    check({tag, "_fcs"}, fcs, ab ? crc : ~crc);
    for (int k = 0; k < 4; k++) rcrc = crc_upd(rcrc, fcs[8*k +: 8]);
    res = bitrev(rcrc);
    if (!ab) check({tag, "_residue"}, res, 32'hC704DD7B);
    else check({tag, "_residue_bad"}, res != 32'hC704DD7B, 1);
    check({tag, "_done_pos"}, frame_done_pos, total - 1);
  endtask

  // Offers tx_bytes[0 .. present_n-1]; data_last on byte len-1 when with_last.
  // rst_at >= 0 pulses reset once that many bytes have been accepted.
  task automatic send_frame(input string tag, input int len, input bit with_last,
                            input int present_n, input int rst_at,
                            input int exp_bytes, input bit exp_abort);
    int idx;
    bit hs, started, done;
    int viol;
    idx = 0; started = 0; done = 0; viol = 0;
    frame_ready = 0;
    underrun_cnt = 0;
    data_valid = 1'b1;
    data_in = tx_bytes[0];
    data_last = with_last && (len == 1);
    hs = data_valid && data_ready;
    for (int c = 0; c < 20000; c++) begin
      @(negedge tx_clk);
      if (hs) idx++;
      if (tx_busy) started = 1;
      if (rst_at >= 0 && idx == rst_at) begin
        reset = 1'b1;
        data_valid = 1'b0;
        data_last = 1'b0;
        @(negedge tx_clk);
        check({tag, "_reset_outputs"},
              {data_ready, tx_dv, tx_d, tx_busy, tx_done, tx_underrun}, 0);
        reset = 1'b0;
        @(negedge tx_clk);
        frame_ready = 0;
        return;
      end
      if (underrun_cnt > 0 && tx_busy && data_ready) viol++;
      if (started && !tx_busy) begin
        done = 1;
        break;
      end
      if (idx < present_n) begin
        data_valid = 1'b1;
        data_in = tx_bytes[idx];
        data_last = with_last && (idx == len - 1);
      end else begin
        data_valid = 1'b0;
        data_last = 1'b0;
      end
      hs = data_valid && data_ready;
    end
    data_valid = 1'b0;
    data_last = 1'b0;
    check({tag, "_completed"}, done, 1);
    check({tag, "_frame_seen"}, frame_ready, 1);
    if (frame_ready) check_frame(tag, exp_bytes, exp_abort);
    check({tag, "_ready_after_abort"}, viol, 0);
  endtask

  initial begin
    int len;
    reset = 1'b1;
    data_valid = 1'b0;
    data_last = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge tx_clk);
    check("reset_outputs", {data_ready, tx_dv, tx_d, tx_busy, tx_done, tx_underrun}, 0);
    reset = 1'b0;
    @(negedge tx_clk);
    check("idle_ready", data_ready, 1);

    // 100-byte frame with Ethernet header
    fill_random(100);
    for (int i = 0; i < 6; i++) begin
      tx_bytes[i]     = 8'hF0 + 8'(i);
      tx_bytes[6 + i] = 8'hE0 + 8'(i);
    end
    tx_bytes[12] = 8'h08;
    tx_bytes[13] = 8'h00;
    send_frame("f100", 100, 1, 100, -1, 100, 0);

    fill_random(20);
    send_frame("f20", 20, 1, 20, -1, 20, 0);

    fill_random(1);
    send_frame("f1", 1, 1, 1, -1, 1, 0);

    // back-to-back 64-byte frames
    fill_random(64);
    send_frame("b2b_a", 64, 1, 64, -1, 64, 0);
    fill_random(64);
    send_frame("b2b_b", 64, 1, 64, -1, 64, 0);
    check("b2b_gap", gap_last, 24);
    check("b2b_since_done", since_done, 25);

    fill_random(100);
    send_frame("underrun", 100, 1, 30, -1, 30, 1);

    fill_random(100);
    send_frame("reset_mid", 100, 1, 100, 40, 0, 0);
    fill_random(60);
    send_frame("after_reset", 60, 1, 60, -1, 60, 0);

    for (int r = 0; r < 4; r++) begin
      len = $urandom_range(1, 130);
      fill_random(len);
      send_frame($sformatf("rand%0d", r), len, 1, len, -1, len, 0);
    end

    fill_random(1515);
    send_frame("oversize", 1515, 0, 1515, -1, 1514, 1);

    check("txd_zero_when_idle", dzero_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
